// File: rtl/bpm_display_mux.sv
// bpm_display_mux
//   Drives a 3-digit multiplexed common-anode 7-segment display from the
//   averaged BPM, given as three BCD digits.
//   - New values are staged and take effect only at a frame boundary, so a
//     frame never shows a mix of old and new digits.
//   - Leading zeros can be blanked, and a non-BCD digit is shown as a dash.
//   - The decimal point of digit 0 is a stretched beat indicator.
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   d2/d1/d0     hundreds/tens/ones BCD digits, sampled when upd=1
//   upd          1-cycle strobe: new value present on d2..d0
//   beat         1-cycle strobe for each detected pulse
//   an[3:0]      digit anodes, active low; an[3] is never driven low
//   seg[6:0]     segments a..g on seg[0]..seg[6], active low
//   dp           decimal point, active low
module bpm_display_mux #(
    parameter int SCAN_DIV = 100000,
    parameter int BEAT_CYC = 10000000,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic       upd,
    input  logic       beat,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int TW = $clog2(BEAT_CYC + 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [2:0][3:0] stage_q, stage_d;
    logic [2:0][3:0] shadow_q, shadow_d;
    logic            pending_q, pending_d;
    logic [TW-1:0]   beat_tmr_q, beat_tmr_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic            last_slot, fb;
    logic [3:0]      cur_dig;
    logic            cur_blank;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = SEG_DASH;   // A-F are not BCD
        endcase
    endfunction

    assign last_slot = (slot_cnt_q == SW'(SCAN_DIV - 1));
    assign fb        = last_slot && (idx_q == 2'd2);

    // Scan, tear-free update and beat timer
    always_comb begin
        slot_cnt_d = last_slot ? '0 : slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (last_slot) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;

        stage_d   = stage_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (fb && (pending_q || upd)) begin
            // Live inputs win over staging when upd lands on the boundary.
            shadow_d  = upd ? {d2, d1, d0} : stage_q;
            pending_d = 1'b0;
        end else if (upd) begin
            stage_d   = {d2, d1, d0};
            pending_d = 1'b1;
        end

        if (beat)                  beat_tmr_d = TW'(BEAT_CYC);
        else if (beat_tmr_q != '0) beat_tmr_d = beat_tmr_q - 1'b1;
        else                       beat_tmr_d = beat_tmr_q;
    end

    // Digit select, blanking and output drive
    always_comb begin
        cur_dig   = shadow_q[0];
        cur_blank = 1'b0;
        an_d      = 4'b1111;
        case (idx_q)
            2'd1: begin
                cur_dig   = shadow_q[1];
                cur_blank = (BLANK_LZ != 0) && (shadow_q[2] == 4'd0) && (shadow_q[1] == 4'd0);
                an_d[1]   = 1'b0;
            end
            2'd2: begin
                cur_dig   = shadow_q[2];
                cur_blank = (BLANK_LZ != 0) && (shadow_q[2] == 4'd0);
                an_d[2]   = 1'b0;
            end
            default: an_d[0] = 1'b0;
        endcase
        seg_d = cur_blank ? SEG_BLANK : glyph(cur_dig);
        dp_d  = !((idx_q == 2'd0) && (beat_tmr_q != '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt_q <= '0;
            idx_q      <= 2'd0;
            stage_q    <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            beat_tmr_q <= '0;
            an_q       <= 4'b1111;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            stage_q    <= stage_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            beat_tmr_q <= beat_tmr_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_bpm_display_mux.sv
// tb_bpm_display_mux
//   Drives bpm_display_mux (SCAN_DIV=4, BEAT_CYC=20) with directed and
//   random upd/beat/reset traffic. Two instances share the inputs: one with
//   leading-zero blanking and one without. A frame-position model predicts
//   the displayed outputs; expectations are queued per cycle and a monitor
//   compares them on the falling edge.
module tb_bpm_display_mux;
    localparam int S  = 4;
    localparam int B  = 20;
    localparam int FR = 3 * S;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [6:0] seg_nb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d2_i, d1_i, d0_i;
    logic       upd_i, beat_i;
    logic [3:0] an, an_nb;
    logic [6:0] seg, seg_nb;
    logic       dp, dp_nb;

    bpm_display_mux #(.SCAN_DIV(S), .BEAT_CYC(B), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .d2(d2_i), .d1(d1_i), .d0(d0_i),
        .upd(upd_i), .beat(beat_i), .an(an), .seg(seg), .dp(dp));

    bpm_display_mux #(.SCAN_DIV(S), .BEAT_CYC(B), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .d2(d2_i), .d1(d1_i), .d0(d0_i),
        .upd(upd_i), .beat(beat_i), .an(an_nb), .seg(seg_nb), .dp(dp_nb));

    always #5 clk = ~clk;

    // Reference model: position within the frame, shown digits, staged digits
    int         pos;
    logic [3:0] sh [3];
    logic [3:0] st [3];
    bit         pend;
    int         tmr;
    bit         in_rst;
    exp_t       q[$];
    int         n_vec = 0;
    int         n_bad = 0;

    localparam exp_t RST_EXP = '{an: 4'b1111, seg: 7'h7F, dp: 1'b1, seg_nb: 7'h7F};

    function automatic logic [6:0] dec(input int k, input bit blz);
        logic [6:0] g [10];
        g = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (sh[k] > 4'd9) return 7'b0111111;
        if (blz && k == 2 && sh[2] == 0) return 7'h7F;
        if (blz && k == 1 && sh[2] == 0 && sh[1] == 0) return 7'h7F;
        return g[sh[k]];
    endfunction

    function automatic exp_t outs();
        exp_t e;
        int   k;
        k        = pos / S;
        e.an     = 4'b1111;
        e.an[k]  = 1'b0;
        e.seg    = dec(k, 1'b1);
        e.seg_nb = dec(k, 1'b0);
        e.dp     = !(k == 0 && tmr != 0);
        return e;
    endfunction

    function automatic void model_clear();
        pos  = 0;
        pend = 0;
        tmr  = 0;
        for (int i = 0; i < 3; i++) begin sh[i] = 0; st[i] = 0; end
    endfunction

    // One clock edge of the model using the inputs presented at that edge.
    function automatic void advance();
        logic [3:0] live [3];
        live = '{d0_i, d1_i, d2_i};
        if (pos == FR - 1 && (pend || upd_i)) begin
            for (int i = 0; i < 3; i++) sh[i] = upd_i ? live[i] : st[i];
            pend = 0;
        end else if (upd_i) begin
            for (int i = 0; i < 3; i++) st[i] = live[i];
            pend = 1;
        end
        tmr = beat_i ? B : (tmr > 0 ? tmr - 1 : 0);
        pos = (pos + 1) % FR;
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk); #1;
        if (in_rst) e = RST_EXP;
        else begin e = outs(); advance(); end
        q.push_back(e);
        upd_i  = 1'b0;
        beat_i = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst    = 1'b0;
        in_rst = 1;
        model_clear();
        q.push_back(RST_EXP);
        upd_i  = 1'b0;
        beat_i = 1'b0;
        run(n - 1);
        @(posedge clk); #1;
        rst = 1'b1;
        q.push_back(RST_EXP);
        in_rst = 0;
    endtask

    task automatic load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        d2_i = a; d1_i = b; d0_i = c; upd_i = 1'b1;
        tick();
    endtask

    function automatic logic [3:0] rdig();
        return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    endfunction

    // Monitor: outputs are valid every cycle; one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (an !== e.an) begin
                    n_bad++; $display("FAIL an: got %b want %b @%0t", an, e.an, $time);
                end
                if (seg !== e.seg) begin
                    n_bad++; $display("FAIL seg: got %b want %b @%0t", seg, e.seg, $time);
                end
                if (dp !== e.dp) begin
                    n_bad++; $display("FAIL dp: got %b want %b @%0t", dp, e.dp, $time);
                end
                if (seg_nb !== e.seg_nb || an_nb !== e.an || dp_nb !== e.dp) begin
                    n_bad++;
                    $display("FAIL nolz: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b @%0t",
                             an_nb, seg_nb, dp_nb, e.an, e.seg_nb, e.dp, $time);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; upd_i = 1'b0; beat_i = 1'b0;
        d2_i = 0; d1_i = 0; d0_i = 0;
        in_rst = 1;
        model_clear();
        run(3);
        @(posedge clk); #1;
        rst = 1'b1;
        q.push_back(RST_EXP);
        in_rst = 0;
        run(2 * FR);                               // idle scan showing "  0"

        while (pos != 1) tick();
        load(4'd1, 4'd2, 4'd3);                    // mid-frame update, tear-free
        run(2 * FR);
        load(4'd0, 4'd0, 4'd7); run(2 * FR);
        load(4'd1, 4'd0, 4'd5); run(2 * FR);
        load(4'd0, 4'hA, 4'd4); run(2 * FR);       // dash, digit 2 stays blank

        load(4'd2, 4'd5, 4'd9);                    // staged, then overwritten
        load(4'd0, 4'd6, 4'd8); run(2 * FR);

        while (pos != FR - 1) tick();
        load(4'd3, 4'd4, 4'd1); run(FR);           // upd exactly at frame boundary

        beat_i = 1'b1; tick(); run(14);
        beat_i = 1'b1; tick(); run(40);            // retrigger extends dp

        while (pos != 2) tick();
        load(4'd9, 4'd9, 4'd9); run(3);
        do_reset(2);                               // pending discarded
        run(2 * FR);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                d2_i   = rdig(); d1_i = rdig(); d0_i = rdig();
                upd_i  = ($urandom_range(0, 7) == 0);
                beat_i = ($urandom_range(0, 29) == 0);
                tick();
            end
        end

        @(posedge clk); @(negedge clk); #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
